mem_arbiter: RTL and testbench

Sole owner of the CPU's single byte-wide RAM/IO port; it time-shares that port between the instruction fetch unit (word reads) and the load/store buffer (byte/half/word loads and stores). Each request is serialised into consecutive single-byte memory cycles, and the assembled result is returned with a one-cycle `done` pulse. The block sits between the fetch and LSB units and the top-level `mem_*` pins, and honours the ROB `clear` flush and the IO buffer back-pressure.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter: state encoding, access
// size codes, the IO region tag and the fetch reset vector.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_state_e;

    localparam logic [1:0]  SZ_B      = 2'd0;
    localparam logic [1:0]  SZ_H      = 2'd1;
    localparam logic [1:0]  SZ_W      = 2'd2;

    localparam logic [1:0]  IO_HI     = 2'b11;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [2:0]  FETCH_LEN = 3'd4;

    // Number of byte cycles for an LSB access of the given size code.
    function automatic logic [2:0] size_len(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_len = 3'd1;
            SZ_H:    size_len = 3'd2;
            SZ_W:    size_len = 3'd4;
            default: size_len = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Owner of the single byte-wide RAM/IO port. Serialises fetch word reads and
// LSB byte/half/word loads and stores into byte cycles, returns assembled
// results with a one-cycle done pulse, honours ROB clear and IO back-pressure.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter logic [1:0] IO_HI = mem_pkg::IO_HI
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata
);

    mem_state_e  state_q;
    logic        last_lsb_q;   // previous grant went to the LSB
    logic        own_lsb_q;    // current transaction belongs to the LSB
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  len_q;
    logic [2:0]  cnt_q;        // read: edge index since grant; write: bytes issued
    logic [23:0] buf_q;        // bytes 0..2 of a read, last byte comes from mem_din
    logic [31:0] mem_a_q;
    logic [7:0]  mem_dout_q;
    logic        mem_wr_q;
    logic        if_done_q;
    logic        lsb_done_q;
    logic [31:0] if_data_q;
    logic [31:0] lsb_rdata_q;

    logic        read_last;
    logic        write_last;
    logic        finishing;
    logic        io_stall;
    logic [1:0]  cap_idx;
    logic [31:0] rd_word;
    logic        if_cand;
    logic        lsb_cand;
    logic        gnt_lsb_d;
    logic        gnt_if_d;
    logic        grant_d;
    logic [31:0] g_addr_d;
    logic [2:0]  g_len_d;
    logic        g_wr_d;
    logic        g_stall_d;

    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q;
    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign lsb_done  = lsb_done_q;
    assign lsb_rdata = lsb_rdata_q;

    // Transaction end detection, read assembly and round-robin arbitration.
    always_comb begin
        read_last  = (state_q == MEM_READ)  && (cnt_q == len_q + 3'd1);
        write_last = (state_q == MEM_WRITE) && (cnt_q == len_q);
        // A flushed read ends without completing, so it cannot hand over the port.
        finishing  = (read_last && !clear) || write_last;
        io_stall   = (addr_q[17:16] == IO_HI) && io_buffer_full;
        cap_idx    = cnt_q[1:0] - 2'd2;

        case (len_q)
            3'd1:    rd_word = {24'd0, mem_din};
            3'd2:    rd_word = {16'd0, mem_din, buf_q[7:0]};
            default: rd_word = {mem_din, buf_q};
        endcase

        // The requester being served this edge is still holding req; skip it.
        if_cand   = if_req  && !(finishing && !own_lsb_q);
        lsb_cand  = lsb_req && !(finishing &&  own_lsb_q);
        gnt_lsb_d = lsb_cand && !(if_cand && last_lsb_q);
        gnt_if_d  = if_cand && !gnt_lsb_d;
        grant_d   = !clear && ((state_q == MEM_IDLE) || finishing)
                    && (gnt_lsb_d || gnt_if_d);

        g_addr_d  = gnt_lsb_d ? lsb_addr : if_addr;
        g_len_d   = gnt_lsb_d ? size_len(lsb_size) : FETCH_LEN;
        g_wr_d    = gnt_lsb_d && lsb_wr;
        g_stall_d = g_wr_d && (g_addr_d[17:16] == IO_HI) && io_buffer_full;
    end

    // Port sequencer: drives byte cycles, captures read data, pulses done.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= MEM_IDLE;
            last_lsb_q  <= 1'b0;
            own_lsb_q   <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            len_q       <= 3'd0;
            cnt_q       <= 3'd0;
            buf_q       <= 24'd0;
            mem_a_q     <= 32'd0;
            mem_dout_q  <= 8'd0;
            mem_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            lsb_done_q  <= 1'b0;
            if_data_q   <= 32'd0;
            lsb_rdata_q <= 32'd0;
        end else if (rdy_in) begin
            if_done_q  <= 1'b0;
            lsb_done_q <= 1'b0;
            mem_wr_q   <= 1'b0;

            case (state_q)
                MEM_READ: begin
                    if (clear) begin
                        state_q <= MEM_IDLE;
                    end else begin
                        if (cnt_q < len_q) begin
                            mem_a_q <= addr_q + {29'd0, cnt_q};
                        end
                        if ((cnt_q >= 3'd2) && (cnt_q <= len_q)) begin
                            buf_q[{cap_idx, 3'b000} +: 8] <= mem_din;
                        end
                        if (read_last) begin
                            state_q <= MEM_IDLE;
                            if (own_lsb_q) begin
                                lsb_rdata_q <= rd_word;
                                lsb_done_q  <= 1'b1;
                            end else begin
                                if_data_q <= rd_word;
                                if_done_q <= 1'b1;
                            end
                        end
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                MEM_WRITE: begin
                    // Stores run to completion even across a flush.
                    if (write_last) begin
                        state_q    <= MEM_IDLE;
                        lsb_done_q <= 1'b1;
                    end else if (!io_stall) begin
                        mem_wr_q   <= 1'b1;
                        mem_a_q    <= addr_q + {29'd0, cnt_q};
                        mem_dout_q <= wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                        cnt_q      <= cnt_q + 3'd1;
                    end
                end
                default: ;
            endcase

            if (grant_d) begin
                state_q    <= g_wr_d ? MEM_WRITE : MEM_READ;
                own_lsb_q  <= gnt_lsb_d;
                last_lsb_q <= gnt_lsb_d;
                addr_q     <= g_addr_d;
                len_q      <= g_len_d;
                wdata_q    <= lsb_wdata;
                if (!g_wr_d) begin
                    mem_a_q <= g_addr_d;
                    cnt_q   <= 3'd1;
                end else if (g_stall_d) begin
                    cnt_q <= 3'd0;
                end else begin
                    mem_wr_q   <= 1'b1;
                    mem_a_q    <= g_addr_d;
                    mem_dout_q <= lsb_wdata[7:0];
                    cnt_q      <= 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM/IO environment, cycle-level reference model with
// a per-cycle compare process, and directed scenarios with literal checks.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        io_buffer_full;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req;
    logic        lsb_wr;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_data(if_data), .lsb_req(lsb_req), .lsb_wr(lsb_wr),
        .lsb_size(lsb_size), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
    );

    // Environment: synchronous RAM (one-edge read latency) and an IO sink.
    logic [7:0] ram [0:4095];
    logic [7:0] io_log [$];

    always @(posedge clk_in) begin
        if (rdy_in) begin
            if (mem_wr) begin
                if (mem_a[17:16] == 2'b11) io_log.push_back(mem_dout);
                else ram[mem_a[11:0]] <= mem_dout;
            end
            mem_din <= ram[mem_a[11:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, advanced once per enabled edge.
    logic        s_clear, s_full, s_if_req, s_lsb_req, s_lsb_wr;
    logic [1:0]  s_size;
    logic [31:0] s_if_addr, s_lsb_addr, s_wdata;

    bit          m_busy, m_lsb, m_wr, m_last_lsb;
    int          m_len, m_n, m_issued;
    logic [31:0] m_addr, m_wdata;

    bit          e_if_done, e_lsb_done, e_wr;
    logic [31:0] e_a, e_if_data, e_lsb_rdata;
    logic [7:0]  e_dout;

    task automatic model_reset();
        m_busy = 0; m_lsb = 0; m_wr = 0; m_last_lsb = 0;
        m_len = 0; m_n = 0; m_issued = 0; m_addr = 0; m_wdata = 0;
        e_if_done = 0; e_lsb_done = 0; e_wr = 0;
        e_a = 0; e_if_data = 0; e_lsb_rdata = 0; e_dout = 0;
    endtask

    task automatic write_step();
        if (m_addr[17:16] == 2'b11 && s_full) begin
            e_wr = 0;
        end else begin
            e_wr   = 1;
            e_a    = m_addr + 32'(m_issued);
            e_dout = 8'(m_wdata >> (8 * m_issued));
            m_issued++;
        end
    endtask

    task automatic model_edge();
        bit          fin, c_if, c_lsb, g_lsb, g_if;
        logic [31:0] d, ak;
        fin = 0;
        e_if_done = 0; e_lsb_done = 0; e_wr = 0;
        if (m_busy && !m_wr) begin
            if (s_clear) begin
                m_busy = 0;
            end else begin
                if (m_n < m_len) e_a = m_addr + 32'(m_n);
                if (m_n == m_len + 1) begin
                    d = 0;
                    for (int k = 0; k < m_len; k++) begin
                        ak = m_addr + 32'(k);
                        d[8*k +: 8] = ram[ak[11:0]];
                    end
                    if (m_lsb) begin e_lsb_done = 1; e_lsb_rdata = d; end
                    else       begin e_if_done  = 1; e_if_data   = d; end
                    m_busy = 0; fin = 1;
                end
                m_n++;
            end
        end else if (m_busy && m_wr) begin
            if (m_issued == m_len) begin
                e_lsb_done = 1; m_busy = 0; fin = 1;
            end else begin
                write_step();
            end
        end
        if (!s_clear && !m_busy) begin
            c_if  = s_if_req  && !(fin && !m_lsb);
            c_lsb = s_lsb_req && !(fin &&  m_lsb);
            g_lsb = (c_if && c_lsb) ? !m_last_lsb : c_lsb;
            g_if  = c_if && !g_lsb;
            if (g_lsb || g_if) begin
                m_busy = 1; m_lsb = g_lsb; m_last_lsb = g_lsb;
                m_addr = g_lsb ? s_lsb_addr : s_if_addr;
                m_len  = g_lsb ? (1 << s_size) : 4;
                m_wr   = g_lsb && s_lsb_wr;
                m_wdata = s_wdata;
                if (!m_wr) begin
                    e_a = m_addr; m_n = 1;
                end else begin
                    m_issued = 0; write_step();
                end
            end
        end
    endtask

    // Compare process: model steps on each edge, outputs checked 1 time unit later.
    initial begin
        model_reset();
        forever begin
            @(posedge clk_in);
            s_clear = clear; s_full = io_buffer_full; s_if_req = if_req;
            s_lsb_req = lsb_req; s_lsb_wr = lsb_wr; s_size = lsb_size;
            s_if_addr = if_addr; s_lsb_addr = lsb_addr; s_wdata = lsb_wdata;
            if (rst_in) model_reset();
            else if (rdy_in) model_edge();
            #1;
            if (rst_in) model_reset();
            chk("cyc_mem_a", mem_a, e_a);
            chk("cyc_mem_wr", {31'd0, mem_wr}, {31'd0, e_wr});
            chk("cyc_if_done", {31'd0, if_done}, {31'd0, e_if_done});
            chk("cyc_lsb_done", {31'd0, lsb_done}, {31'd0, e_lsb_done});
            if (e_wr)       chk("cyc_mem_dout", {24'd0, mem_dout}, {24'd0, e_dout});
            if (e_if_done)  chk("cyc_if_data", if_data, e_if_data);
            if (e_lsb_done) chk("cyc_lsb_rdata", lsb_rdata, e_lsb_rdata);
        end
    end

    task automatic wait_done(input bit want_lsb, output int cyc);
        logic seen;
        cyc = 0; seen = 0;
        while (!seen && cyc < 30) begin
            @(negedge clk_in);
            cyc++;
            seen = want_lsb ? lsb_done : if_done;
        end
        chk(want_lsb ? "lsb_done_seen" : "if_done_seen", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    // Directed scenarios.
    initial begin
        int cyc;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
        ram[12'h1FF] = 8'hFF; ram[12'h200] = 8'h80;
        ram[12'hFFE] = 8'h11; ram[12'hFFF] = 8'h22; ram[12'h000] = 8'h33; ram[12'h001] = 8'h44;

        rst_in = 1; rdy_in = 1; clear = 0; io_buffer_full = 0;
        if_req = 0; if_addr = 0; lsb_req = 0; lsb_wr = 0; lsb_size = 0;
        lsb_addr = 0; lsb_wdata = 0;
        repeat (2) @(negedge clk_in);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'h0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_lsb_rdata", lsb_rdata, 32'h0);
        chk("rst_dones", {30'd0, if_done, lsb_done}, 32'h0);
        rst_in = 0;
        @(negedge clk_in);

        // Fetch only at 0x100
        if_req = 1; if_addr = 32'h100;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_in);
            if (k <= 4) chk("fetch_addr", mem_a, 32'h100 + 32'(k - 1));
            if (k < 6)  chk("fetch_early_done", {31'd0, if_done}, 32'd0);
        end
        chk("fetch_done", {31'd0, if_done}, 32'd1);
        chk("fetch_data", if_data, 32'h0000_0513);
        if_req = 0;
        @(negedge clk_in);
        chk("fetch_single_pulse", {31'd0, if_done}, 32'd0);

        // LSB half load then byte load at 0x1FF
        lsb_req = 1; lsb_wr = 0; lsb_size = 2'd1; lsb_addr = 32'h1FF;
        wait_done(1, cyc);
        chk("half_latency", 32'(cyc), 32'd4);
        chk("half_data", lsb_rdata, 32'h0000_80FF);
        lsb_req = 0;
        @(negedge clk_in);
        chk("half_single_pulse", {31'd0, lsb_done}, 32'd0);
        lsb_req = 1; lsb_size = 2'd0;
        wait_done(1, cyc);
        chk("byte_latency", 32'(cyc), 32'd3);
        chk("byte_data", lsb_rdata, 32'h0000_00FF);
        lsb_req = 0;
        @(negedge clk_in);

        // Fetch wrapping past 0xFFFFFFFF (also leaves last grant with fetch)
        if_req = 1; if_addr = 32'hFFFF_FFFE;
        wait_done(0, cyc);
        chk("wrap_data", if_data, 32'h4433_2211);
        if_req = 0;
        @(negedge clk_in);

        // Both requesters: store first, then fetch although LSB reasserts
        if_req = 1; if_addr = 32'h100;
        lsb_req = 1; lsb_wr = 1; lsb_size = 2'd2; lsb_addr = 32'h40; lsb_wdata = 32'hDEAD_BEEF;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_in);
            chk("both_wr", {31'd0, mem_wr}, 32'd1);
            chk("both_addr", mem_a, 32'h40 + 32'(k - 1));
        end
        // Bytes checked above by address; byte order pinned via RAM image below.
        @(negedge clk_in);
        chk("both_store_done", {31'd0, lsb_done}, 32'd1);
        chk("both_fetch_granted", mem_a, 32'h100);
        lsb_req = 0;
        @(negedge clk_in);
        lsb_req = 1; lsb_wr = 0; lsb_size = 2'd0; lsb_addr = 32'h41;
        wait_done(0, cyc);
        chk("both_fetch_lat", 32'(cyc), 32'd4);
        chk("both_fetch_data", if_data, 32'h0000_0513);
        if_req = 0;
        wait_done(1, cyc);
        chk("both_load_lat", 32'(cyc), 32'd2);
        chk("both_load_data", lsb_rdata, 32'h0000_00BE);
        lsb_req = 0;
        chk("store_image", {ram[12'h043], ram[12'h042], ram[12'h041], ram[12'h040]}, 32'hDEAD_BEEF);
        @(negedge clk_in);

        // IO store with 3 cycles of back-pressure
        lsb_req = 1; lsb_wr = 1; lsb_size = 2'd0; lsb_addr = 32'h0003_0000; lsb_wdata = 32'h0000_00A5;
        io_buffer_full = 1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_in);
            chk("io_stall_wr", {31'd0, mem_wr}, 32'd0);
            if (k == 3) io_buffer_full = 0;
        end
        @(negedge clk_in);
        chk("io_write_wr", {31'd0, mem_wr}, 32'd1);
        chk("io_write_byte", {24'd0, mem_dout}, 32'h0000_00A5);
        @(negedge clk_in);
        chk("io_done_late", {31'd0, lsb_done}, 32'd1);
        lsb_req = 0;
        chk("io_log_size", 32'(io_log.size()), 32'd1);
        if (io_log.size() == 1) chk("io_log_byte", {24'd0, io_log[0]}, 32'h0000_00A5);
        @(negedge clk_in);

        // Clear mid-fetch after two bytes captured
        if_req = 1; if_addr = 32'h100;
        repeat (4) @(negedge clk_in);
        clear = 1; if_req = 0;
        @(negedge clk_in);
        clear = 0;
        chk("clr_fetch_wr", {31'd0, mem_wr}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            chk("clr_fetch_no_done", {31'd0, if_done}, 32'd0);
            @(negedge clk_in);
        end
        // Request alongside clear is not granted
        if_req = 1; if_addr = 32'h100; clear = 1;
        @(negedge clk_in);
        clear = 0;
        wait_done(0, cyc);
        chk("clr_req_lat", 32'(cyc), 32'd6);
        if_req = 0;
        @(negedge clk_in);

        // Clear mid-store: store still completes
        lsb_req = 1; lsb_wr = 1; lsb_size = 2'd2; lsb_addr = 32'h80; lsb_wdata = 32'h0BAD_F00D;
        repeat (2) @(negedge clk_in);
        clear = 1;
        @(negedge clk_in);
        clear = 0;
        wait_done(1, cyc);
        chk("clr_store_lat", 32'(cyc), 32'd2);
        lsb_req = 0;
        @(negedge clk_in);
        chk("clr_store_image", {ram[12'h083], ram[12'h082], ram[12'h081], ram[12'h080]}, 32'h0BAD_F00D);

        // rdy_in freeze for two edges during a fetch
        if_req = 1; if_addr = 32'h100;
        repeat (2) @(negedge clk_in);
        rdy_in = 0;
        repeat (2) begin
            @(negedge clk_in);
            chk("rdy_hold_addr", mem_a, 32'h101);
        end
        rdy_in = 1;
        wait_done(0, cyc);
        chk("rdy_latency", 32'(cyc), 32'd4);
        chk("rdy_data", if_data, 32'h0000_0513);
        if_req = 0;
        @(negedge clk_in);

        // Asynchronous reset mid-read
        if_req = 1; if_addr = 32'h100;
        repeat (3) @(negedge clk_in);
        #2 rst_in = 1;
        #1;
        chk("arst_mem_a", mem_a, 32'h0);
        chk("arst_if_data", if_data, 32'h0);
        chk("arst_lsb_rdata", lsb_rdata, 32'h0);
        chk("arst_mem_wr", {31'd0, mem_wr}, 32'h0);
        if_req = 0;
        @(negedge clk_in);
        rst_in = 0;
        @(negedge clk_in);
        if_req = 1; if_addr = 32'h100;
        wait_done(0, cyc);
        chk("arst_after_lat", 32'(cyc), 32'd6);
        chk("arst_after_data", if_data, 32'h0000_0513);
        if_req = 0;
        repeat (2) @(negedge clk_in);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
